bus_release_arbiter: RTL and testbench
======================================

Name: bus_release_arbiter

Overview:
Parametrised successor to the single-DMA CPU halt/bus-mux logic in the 7800 top level. It arbitrates the system address bus among the 6502 and NUM_DMA DMA masters (MARIA, future cart/expansion DMA). It runs the CPU halt/release handshake on pclk1, muxes the address bus and RW, gates halting until the INPUTCTRL register has been written ARM_WRITES times, and tracks open bus and the last address. It sits between the M6502C wrapper, the DMA masters and the chip-select/read-data logic.

Parameters:
NUM_DMA, 2, number of DMA masters (1..8)
ADDR_W, 16, address bus width
DATA_W, 8, data bus width
ARM_WRITES, 2, count of qualified ctrl writes before halt requests are honoured (1..3)

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
pclk0  in  1  phi2 clock enable
pclk1  in  1  phi1 clock enable; all handshake state changes occur only on it
bypass_arm  in  1  force armed state (BIOS bypass)
ctrl_write  in  1  INPUTCTRL write strobe, counted only when pclk0=1
cpu_ab  in  ADDR_W  CPU address
cpu_rw  in  1  CPU read/write_n
dma_req  in  NUM_DMA  per-master bus request
dma_drive  in  NUM_DMA  per-master address-drive enable
dma_ab  in  NUM_DMA*ADDR_W  packed per-master addresses, master i at [i*ADDR_W +: ADDR_W]
rdy_in  in  NUM_DMA+1  ready inputs (MARIA, TIA, ...)
read_db  in  DATA_W  muxed read data
write_db  in  DATA_W  CPU write data
cpu_halt_n  out  1  halt request to CPU wrapper
cpu_released  out  1  CPU has released the bus
rdy_out  out  1  AND of rdy_in
dma_grant  out  NUM_DMA  one-hot grant
AB  out  ADDR_W  system address bus
RW  out  1  system read/write_n
open_bus  out  DATA_W  registered open-bus value
last_address  out  ADDR_W  registered previous AB
armed  out  1  halt gating satisfied

Behaviour:
- Reset values: cpu_halt_n=1, cpu_released=0, dma_grant=0, armed=0, arm count=0, open_bus=0, last_address=0, state=RUN. A reset mid-transfer returns everything to these values on the same edge.
- Arm counter: increments on ctrl_write&pclk0 and saturates at ARM_WRITES. armed=1 when count==ARM_WRITES or when bypass_arm has been seen since reset (sticky). Reset is the only way to clear it.
- FSM, evaluated only on pclk1 edges:
  - RUN: if armed and |dma_req, then cpu_halt_n<=0 and go to HALT_PEND.
  - HALT_PEND: cpu_released<=1, dma_grant<=winner of dma_req, go to GRANT. If no request remains, grant nothing and still go to GRANT.
  - GRANT: if the granted request is still high, hold. Otherwise, if another request is high, move dma_grant to the next winner on this pclk1 with no idle slot. Otherwise dma_grant<=0, cpu_halt_n<=1, and go to RESUME.
  - RESUME: cpu_released<=0, go to RUN. A request arriving in RESUME waits for RUN; total minimum re-halt latency is 2 pclk1.
- Winner selection: fixed priority, lowest index wins (see option).
- Handshake latency: from request high at a pclk1 to dma_grant high is 2 pclk1. From last request low to cpu_released=0 is 2 pclk1.
- AB, combinational:
  - When released with a grant: dma_ab[grant].
  - When released with no grant: last_address.
  - When not released with no dma_drive: cpu_ab.
  - When not released with any dma_drive: cpu_ab ANDed with every driving dma_ab (wired-AND conflict emulation).
- RW = cpu_released ? 1 : cpu_rw.
- rdy_out = &rdy_in, combinational.
- Every clk_sys edge: open_bus<=(~RW ? write_db : read_db) and last_address<=AB.
- If armed is still 0, requests are ignored entirely and the CPU never halts.

Optional Feature:
BUS_ARB_ROUND_ROBIN_EN: when defined, winner selection is round-robin. The search starts at the index after the last granted master, wrapping at NUM_DMA-1→0, and the pointer updates on each grant. When undefined, fixed lowest-index priority applies and no pointer register exists.

Test Plan:
- Reset, then dma_req=01 with armed=0 → cpu_halt_n stays 1 and AB==cpu_ab indefinitely.
- Two pclk0-qualified ctrl_write pulses, then dma_req=01 and dma_ab[0]=16'h1F00 → cpu_halt_n=0 after 1 pclk1; after 2 pclk1, cpu_released=1, dma_grant=01, AB=16'h1F00, RW=1.
- Drop dma_req while granted → after 1 pclk1, dma_grant=0, AB=last_address, cpu_halt_n=1; after 2 pclk1, cpu_released=0 and AB=cpu_ab.
- dma_req=11 held with master 0 granted, then master 0 drops → dma_grant=10 on the next pclk1 with no idle slot. Under BUS_ARB_ROUND_ROBIN_EN, simultaneous 11 after a grant to 0 yields grant 10.
- Not released, cpu_ab=16'hFFF0, dma_drive=01, dma_ab[0]=16'h0F3C → AB=16'h0F30. Write cycle with write_db=8'hA5 → open_bus=8'hA5 on the next clk_sys.
- Assert reset while in GRANT → next edge: cpu_halt_n=1, cpu_released=0, dma_grant=0, armed=0.

Source files
------------

// File: rtl/bus_release_arbiter.sv
// bus_release_arbiter: arbitrates the system address bus between the 6502 and
// NUM_DMA DMA masters. The CPU halt/release handshake advances only on pclk1.
// Halting is held off until INPUTCTRL has been written ARM_WRITES times, or
// until bypass_arm has been seen. The block also tracks open bus and the
// previous address.
// Optional build macro: BUS_ARB_ROUND_ROBIN_EN selects round-robin winner
// selection. When it is undefined, the lowest requesting index wins.
module bus_release_arbiter #(
  parameter int NUM_DMA    = 2,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int ARM_WRITES = 2
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      pclk0,
  input  logic                      pclk1,
  input  logic                      bypass_arm,
  input  logic                      ctrl_write,
  input  logic [ADDR_W-1:0]         cpu_ab,
  input  logic                      cpu_rw,
  input  logic [NUM_DMA-1:0]        dma_req,
  input  logic [NUM_DMA-1:0]        dma_drive,
  input  logic [NUM_DMA*ADDR_W-1:0] dma_ab,
  input  logic [NUM_DMA:0]          rdy_in,
  input  logic [DATA_W-1:0]         read_db,
  input  logic [DATA_W-1:0]         write_db,
  output logic                      cpu_halt_n,
  output logic                      cpu_released,
  output logic                      rdy_out,
  output logic [NUM_DMA-1:0]        dma_grant,
  output logic [ADDR_W-1:0]         AB,
  output logic                      RW,
  output logic [DATA_W-1:0]         open_bus,
  output logic [ADDR_W-1:0]         last_address,
  output logic                      armed
);

  typedef enum logic [1:0] {RUN, HALT_PEND, GRANT, RESUME} state_t;

  state_t               state_q;
  logic                 halt_n_q, released_q;
  logic [NUM_DMA-1:0]   grant_q, win;
  logic [1:0]           arm_cnt_q;
  logic                 bypass_q;
  logic [DATA_W-1:0]    open_bus_q;
  logic [ADDR_W-1:0]    last_q, ab_grant, ab_wand;

  assign armed = (arm_cnt_q == 2'(ARM_WRITES)) | bypass_q;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  localparam int PTR_W = (NUM_DMA > 1) ? $clog2(NUM_DMA) : 1;
  logic [PTR_W-1:0] ptr_q, win_idx;

  // Round-robin search: start just after the last granted master and wrap.
  always_comb begin
    win     = '0;
    win_idx = ptr_q;
    for (int k = NUM_DMA; k >= 1; k--) begin
      if (dma_req[(int'(ptr_q) + k) % NUM_DMA]) begin
        win     = '0;
        win[(int'(ptr_q) + k) % NUM_DMA] = 1'b1;
        win_idx = PTR_W'((int'(ptr_q) + k) % NUM_DMA);
      end
    end
  end

  // Pointer follows every nonzero grant decision.
  always_ff @(posedge clk_sys) begin
    if (reset)
      ptr_q <= '0;
    else if (pclk1 && |win &&
             (state_q == HALT_PEND || (state_q == GRANT && !(|(grant_q & dma_req)))))
      ptr_q <= win_idx;
  end
`else
  // Fixed priority: isolate the lowest set request bit.
  always_comb win = dma_req & (~dma_req + 1'b1);
`endif

  // Arm counter saturates at ARM_WRITES; bypass is sticky until reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      arm_cnt_q <= '0;
      bypass_q  <= 1'b0;
    end else begin
      if (bypass_arm) bypass_q <= 1'b1;
      if (ctrl_write && pclk0 && arm_cnt_q != 2'(ARM_WRITES))
        arm_cnt_q <= arm_cnt_q + 2'd1;
    end
  end

  // Halt/release handshake; the outputs are registered and change only on pclk1.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= RUN;
      halt_n_q   <= 1'b1;
      released_q <= 1'b0;
      grant_q    <= '0;
    end else if (pclk1) begin
      case (state_q)
        RUN: if (armed && |dma_req) begin
          halt_n_q <= 1'b0;
          state_q  <= HALT_PEND;
        end
        HALT_PEND: begin
          released_q <= 1'b1;
          grant_q    <= win;
          state_q    <= GRANT;
        end
        GRANT: if (!(|(grant_q & dma_req))) begin
          if (|dma_req) begin
            grant_q <= win;            // hand straight over, no idle slot
          end else begin
            grant_q  <= '0;
            halt_n_q <= 1'b1;
            state_q  <= RESUME;
          end
        end
        RESUME: begin
          released_q <= 1'b0;
          state_q    <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Address of the granted master, and the wired-AND of the CPU with every driving master.
  always_comb begin
    ab_grant = '0;
    ab_wand  = cpu_ab;
    for (int i = 0; i < NUM_DMA; i++) begin
      if (grant_q[i])   ab_grant = ab_grant | dma_ab[i*ADDR_W +: ADDR_W];
      if (dma_drive[i]) ab_wand  = ab_wand & dma_ab[i*ADDR_W +: ADDR_W];
    end
  end

  assign AB      = released_q ? (|grant_q ? ab_grant : last_q) : ab_wand;
  assign RW      = released_q ? 1'b1 : cpu_rw;
  assign rdy_out = &rdy_in;

  // Open bus and the previous address are captured on every clock.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      open_bus_q <= '0;
      last_q     <= '0;
    end else begin
      open_bus_q <= ~RW ? write_db : read_db;
      last_q     <= AB;
    end
  end

  assign cpu_halt_n   = halt_n_q;
  assign cpu_released = released_q;
  assign dma_grant    = grant_q;
  assign open_bus     = open_bus_q;
  assign last_address = last_q;

endmodule

// File: tb/tb_bus_release_arbiter.sv
// Testbench for bus_release_arbiter. Table vectors and hand sequences push
// their expected values into a scoreboard queue. The queue is drained after
// each clock edge.
module tb_bus_release_arbiter;
  logic clk_sys = 0, reset = 1, pclk0 = 0, pclk1 = 0, bypass_arm = 0, ctrl_write = 0;
  logic [15:0] cpu_ab = 16'h1234;
  logic        cpu_rw = 1;
  logic [1:0]  dma_req = 0, dma_drive = 0;
  logic [15:0] ab0 = 16'h1F00, ab1 = 16'h2A00;
  logic [2:0]  rdy_in = 3'b111;
  logic [7:0]  read_db = 0, write_db = 0;
  logic        cpu_halt_n, cpu_released, rdy_out, RW, armed;
  logic [1:0]  dma_grant;
  logic [15:0] AB, last_address;
  logic [7:0]  open_bus;

  bus_release_arbiter dut (
    .clk_sys(clk_sys), .reset(reset), .pclk0(pclk0), .pclk1(pclk1),
    .bypass_arm(bypass_arm), .ctrl_write(ctrl_write), .cpu_ab(cpu_ab), .cpu_rw(cpu_rw),
    .dma_req(dma_req), .dma_drive(dma_drive), .dma_ab({ab1, ab0}), .rdy_in(rdy_in),
    .read_db(read_db), .write_db(write_db), .cpu_halt_n(cpu_halt_n),
    .cpu_released(cpu_released), .rdy_out(rdy_out), .dma_grant(dma_grant), .AB(AB),
    .RW(RW), .open_bus(open_bus), .last_address(last_address), .armed(armed));

  always #5 clk_sys = ~clk_sys;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  localparam logic [1:0]  SIM_G  = 2'b10;
  localparam logic [15:0] SIM_AB = 16'h2A00;
`else
  localparam logic [1:0]  SIM_G  = 2'b01;
  localparam logic [15:0] SIM_AB = 16'h1F00;
`endif

  typedef struct packed {
    logic p0, p1, cw; logic [1:0] req; logic rw;
    logic e_halt_n, e_rel; logic [1:0] e_grant; logic [15:0] e_ab; logic e_rw, e_armed;
  } vec_t;
  typedef struct { int sel; logic [31:0] exp; string name; } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int checks = 0, failures = 0;

  function automatic logic [31:0] actual(int sel);
    case (sel)
      0: return 32'(cpu_halt_n);
      1: return 32'(cpu_released);
      2: return 32'(dma_grant);
      3: return 32'(AB);
      4: return 32'(RW);
      5: return 32'(armed);
      6: return 32'(open_bus);
      7: return 32'(last_address);
      default: return 32'(rdy_out);
    endcase
  endfunction

  task automatic expect_v(int sel, logic [31:0] e, string nm);
    exp_t x;
    x.sel = sel; x.exp = e; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    logic [31:0] a;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      a = actual(x.sel);
      checks++;
      if (a !== x.exp) begin
        failures++;
        $display("FAIL %s: got %0h expected %0h (t=%0t)", x.name, a, x.exp, $time);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //                p0 p1 cw req  rw  halt rel grant  AB        RW armed
    tbl.push_back('{1'b0,1'b1,1'b0,2'b01,1'b1, 1'b1,1'b0,2'b00,16'h1234,1'b1,1'b0}); // unarmed: ignored
    tbl.push_back('{1'b0,1'b1,1'b0,2'b01,1'b1, 1'b1,1'b0,2'b00,16'h1234,1'b1,1'b0});
    tbl.push_back('{1'b0,1'b0,1'b1,2'b00,1'b1, 1'b1,1'b0,2'b00,16'h1234,1'b1,1'b0}); // write w/o pclk0
    tbl.push_back('{1'b1,1'b0,1'b1,2'b00,1'b1, 1'b1,1'b0,2'b00,16'h1234,1'b1,1'b0}); // count 1
    tbl.push_back('{1'b1,1'b0,1'b1,2'b00,1'b1, 1'b1,1'b0,2'b00,16'h1234,1'b1,1'b1}); // count 2: armed
    tbl.push_back('{1'b0,1'b0,1'b0,2'b01,1'b1, 1'b1,1'b0,2'b00,16'h1234,1'b1,1'b1}); // no pclk1
    tbl.push_back('{1'b0,1'b1,1'b0,2'b01,1'b0, 1'b0,1'b0,2'b00,16'h1234,1'b0,1'b1}); // halt
    tbl.push_back('{1'b0,1'b1,1'b0,2'b01,1'b0, 1'b0,1'b1,2'b01,16'h1F00,1'b1,1'b1}); // grant 0
    tbl.push_back('{1'b0,1'b1,1'b0,2'b11,1'b1, 1'b0,1'b1,2'b01,16'h1F00,1'b1,1'b1}); // hold
    tbl.push_back('{1'b0,1'b0,1'b0,2'b10,1'b1, 1'b0,1'b1,2'b01,16'h1F00,1'b1,1'b1}); // wait pclk1
    tbl.push_back('{1'b0,1'b1,1'b0,2'b10,1'b1, 1'b0,1'b1,2'b10,16'h2A00,1'b1,1'b1}); // hand-off
    tbl.push_back('{1'b0,1'b1,1'b0,2'b00,1'b1, 1'b1,1'b1,2'b00,16'h2A00,1'b1,1'b1}); // AB=last
    tbl.push_back('{1'b0,1'b1,1'b0,2'b01,1'b1, 1'b1,1'b0,2'b00,16'h1234,1'b1,1'b1}); // resume
    tbl.push_back('{1'b0,1'b1,1'b0,2'b01,1'b1, 1'b0,1'b0,2'b00,16'h1234,1'b1,1'b1}); // re-halt
    tbl.push_back('{1'b0,1'b1,1'b0,2'b01,1'b1, 1'b0,1'b1,2'b01,16'h1F00,1'b1,1'b1});
    tbl.push_back('{1'b0,1'b1,1'b0,2'b00,1'b1, 1'b1,1'b1,2'b00,16'h1F00,1'b1,1'b1});
    tbl.push_back('{1'b0,1'b1,1'b0,2'b00,1'b1, 1'b1,1'b0,2'b00,16'h1234,1'b1,1'b1});
    tbl.push_back('{1'b0,1'b1,1'b0,2'b11,1'b1, 1'b0,1'b0,2'b00,16'h1234,1'b1,1'b1});
    tbl.push_back('{1'b0,1'b1,1'b0,2'b11,1'b1, 1'b0,1'b1,SIM_G,SIM_AB,1'b1,1'b1}); // simultaneous
    tbl.push_back('{1'b1,1'b1,1'b1,2'b11,1'b1, 1'b0,1'b1,SIM_G,SIM_AB,1'b1,1'b1}); // saturate

    // Reset state
    tick(); tick();
    expect_v(0, 1, "rst_halt_n"); expect_v(1, 0, "rst_released");
    expect_v(2, 0, "rst_grant");  expect_v(5, 0, "rst_armed");
    expect_v(6, 0, "rst_open_bus"); expect_v(7, 0, "rst_last_addr");
    expect_v(3, 16'h1234, "rst_AB");
    drain();
    reset = 0;

    foreach (tbl[i]) begin
      pclk0 = tbl[i].p0; pclk1 = tbl[i].p1; ctrl_write = tbl[i].cw;
      dma_req = tbl[i].req; cpu_rw = tbl[i].rw;
      expect_v(0, 32'(tbl[i].e_halt_n), $sformatf("v%0d_halt_n", i));
      expect_v(1, 32'(tbl[i].e_rel),    $sformatf("v%0d_released", i));
      expect_v(2, 32'(tbl[i].e_grant),  $sformatf("v%0d_grant", i));
      expect_v(3, 32'(tbl[i].e_ab),     $sformatf("v%0d_AB", i));
      expect_v(4, 32'(tbl[i].e_rw),     $sformatf("v%0d_RW", i));
      expect_v(5, 32'(tbl[i].e_armed),  $sformatf("v%0d_armed", i));
      tick();
      drain();
    end

    // Reset while in GRANT clears everything on the same edge
    reset = 1;
    expect_v(0, 1, "midrst_halt_n"); expect_v(1, 0, "midrst_released");
    expect_v(2, 0, "midrst_grant");  expect_v(5, 0, "midrst_armed");
    expect_v(3, 16'h1234, "midrst_AB");
    tick(); drain();
    reset = 0; pclk0 = 0; pclk1 = 0; ctrl_write = 0; dma_req = 0;

    // Wired-AND conflict while not released, then open-bus capture
    cpu_ab = 16'hFFF0; dma_drive = 2'b01; ab0 = 16'h0F3C;
    #1;
    expect_v(3, 16'h0F30, "wand_AB");
    drain();
    cpu_rw = 0; write_db = 8'hA5; read_db = 8'h3C;
    expect_v(6, 8'hA5, "open_bus_write"); expect_v(7, 16'h0F30, "last_addr_wand");
    tick(); drain();
    cpu_rw = 1; dma_drive = 2'b00;
    expect_v(6, 8'h3C, "open_bus_read"); expect_v(7, 16'hFFF0, "last_addr_cpu");
    tick(); drain();

    // Ready AND
    rdy_in = 3'b111; #1; expect_v(8, 1, "rdy_all"); drain();
    rdy_in = 3'b101; #1; expect_v(8, 0, "rdy_one_low"); drain();

    // Sticky bypass arms halting without ctrl writes
    bypass_arm = 1;
    expect_v(5, 1, "bypass_armed");
    tick(); drain();
    bypass_arm = 0;
    expect_v(5, 1, "bypass_sticky");
    tick(); drain();
    pclk1 = 1; dma_req = 2'b01;
    expect_v(0, 0, "bypass_halt");
    tick(); drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
